uart_rx: RTL and testbench

- UART receiver; the counterpart of the existing UART transmitter.
- Recovers 8N1 frames (1 start bit, FRAME_WIDTH data bits LSB first, 1 stop bit, no parity) from a serial line.
- Each bit is sampled at its mid-point using a clock-cycle counter.
- Presents each received byte on a parallel output with a one-cycle done strobe.
- Sits on the serial input pin; intended for loopback against the transmitter at the same baud rate (100 MHz clk, 9600 baud).

---
 rtl/uart_rx_if.sv | 22 ++
 rtl/uart_rx.sv | 117 +++++++++++
 tb/tb_uart_rx.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial-line side and parallel-result side of the UART receiver.
// The slave modport is the receiver; the master modport is whatever drives the line.
interface uart_rx_if #(
    parameter int FRAME_WIDTH = 8
);
    logic                   rx_en;
    logic                   rx;
    logic [FRAME_WIDTH-1:0] data;
    logic                   done;
    logic                   busy;
    logic                   frame_err;

    modport master (
        output rx_en, rx,
        input  data, done, busy, frame_err
    );

    modport slave (
        input  rx_en, rx,
        output data, done, busy, frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver for 8N1-style frames; each bit is sampled at its mid-point.
// state     | meaning
// IDLE      | line idle, waiting for a falling edge while rx_en=1
// START     | counting to the start-bit centre to confirm a real start
// DATA      | sampling FRAME_WIDTH data bits, LSB first
// STOP      | waiting for the stop-bit centre; high = good frame, low = framing error
// WAIT_IDLE | line stuck low after a framing error; wait for it to go high
module uart_rx #(
    parameter int FRAME_WIDTH  = 8,
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  bus
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(FRAME_WIDTH + 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   w_rx_s;
    logic [CW-1:0]          r_cnt;
    logic [BW-1:0]          r_bit;
    logic [FRAME_WIDTH-1:0] r_shift;
    logic [FRAME_WIDTH-1:0] r_data;
    logic                   r_done;
    logic                   r_ferr;
    logic                   w_busy;
    logic                   w_start_end;
    logic                   w_bit_end;

    assign w_rx_s      = r_sync2;
    assign w_start_end = (r_state == S_START) && (r_cnt == HALF_M1);
    assign w_bit_end   = ((r_state == S_DATA) || (r_state == S_STOP)) && (r_cnt == BIT_M1);

    // Preset high so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (bus.rx_en && !w_rx_s) w_next = S_START;
            S_START:     if (w_start_end) w_next = w_rx_s ? S_IDLE : S_DATA;
            S_DATA:      if (w_bit_end && (r_bit == LAST_BIT)) w_next = S_STOP;
            S_STOP:      if (w_bit_end) w_next = w_rx_s ? S_IDLE : S_WAIT_IDLE;
            S_WAIT_IDLE: if (w_rx_s) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) || (r_state == S_WAIT_IDLE) || w_start_end || w_bit_end)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CW'(1);

            if (r_state != S_DATA)
                r_bit <= '0;
            else if (w_bit_end)
                r_bit <= r_bit + BW'(1);

            // Shifting right at the MSB end leaves the first (LSB) bit at [0].
            if ((r_state == S_DATA) && w_bit_end)
                r_shift <= {w_rx_s, r_shift[FRAME_WIDTH-1:1]};

            if ((r_state == S_STOP) && w_bit_end && w_rx_s)
                r_data <= r_shift;

            r_done <= (r_state == S_STOP) && w_bit_end && w_rx_s;
            r_ferr <= (r_state == S_STOP) && w_bit_end && !w_rx_s;
        end
    end

    assign bus.data      = r_data;
    assign bus.done      = r_done;
    assign bus.busy      = w_busy;
    assign bus.frame_err = r_ferr;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus a randomized frame stream,
// compared every cycle against a frame-timing model of the receiver.
module tb_uart_rx;
    localparam int CPB  = 16;
    localparam int FW   = 8;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 3 + HALF + (FW + 1) * CPB;
    localparam int MAXC = 16384;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   n_done = 0;
    int   n_ferr = 0;
    int   last_done = -1;
    int   last_ferr = -1;

    bit         exp_busy [MAXC];
    bit         exp_done [MAXC];
    bit         exp_ferr [MAXC];
    bit         exp_load [MAXC];
    logic [7:0] exp_val  [MAXC];
    logic [7:0] mdata = 8'h00;

    uart_rx_if #(.FRAME_WIDTH(FW)) bus ();

    uart_rx #(.FRAME_WIDTH(FW), .CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sched_busy(input int a, input int b);
        for (int c = a; c < b; c++)
            if (c >= 0 && c < MAXC) exp_busy[c] = 1'b1;
    endtask

    // Line-level model: a start edge driven at cycle s is seen 3 cycles later,
    // and the stop-bit result appears LAT cycles after s.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit en,
                              input int low_hold, input bit drop_en);
        int s;
        int p;
        s = cyc;
        p = s + LAT;
        if (en && p < MAXC) begin
            if (stop_ok) begin
                sched_busy(s + 3, p);
                exp_done[p] = 1'b1;
                exp_load[p] = 1'b1;
                exp_val[p]  = b;
            end else begin
                sched_busy(s + 3, s + (FW + 2) * CPB + low_hold + 3);
                exp_ferr[p] = 1'b1;
            end
        end
        bus.rx_en = en;
        bus.rx    = 1'b0;
        tick(CPB);
        for (int i = 0; i < FW; i++) begin
            bus.rx = b[i];
            if (drop_en && i == 0) bus.rx_en = 1'b0;
            tick(CPB);
        end
        bus.rx = stop_ok;
        tick(CPB);
        if (!stop_ok) begin
            tick(low_hold);
            bus.rx = 1'b1;
            tick(1);
        end
        bus.rx = 1'b1;
    endtask

    task automatic glitch(input int len, input bit en);
        int s;
        s = cyc;
        if (en) sched_busy(s + 3, s + 3 + HALF);
        bus.rx_en = en;
        bus.rx    = 1'b0;
        tick(len);
        bus.rx = 1'b1;
        tick(HALF + 4 - len);
    endtask

    always @(negedge clk) begin
        if (bus.done) begin
            n_done++;
            last_done = cyc;
        end
        if (bus.frame_err) begin
            n_ferr++;
            last_ferr = cyc;
        end
    end

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            if (!rst) mdata = 8'h00;
            else if (exp_load[cyc]) mdata = exp_val[cyc];
            chk("busy", {31'd0, bus.busy}, {31'd0, exp_busy[cyc]});
            chk("done", {31'd0, bus.done}, {31'd0, exp_done[cyc]});
            chk("frame_err", {31'd0, bus.frame_err}, {31'd0, exp_ferr[cyc]});
            chk("data", {24'd0, bus.data}, {24'd0, mdata});
        end
    end

    initial begin
        int s;
        int nd;
        int nf;
        int kind;
        logic [7:0] b;

        bus.rx    = 1'b1;
        bus.rx_en = 1'b0;
        rst       = 1'b0;
        #20 rst = 1'b1;
        tick(100);
        chk("reset_data", {24'd0, bus.data}, 32'h0);
        chk("reset_busy", {31'd0, bus.busy}, 32'h0);

        nd = n_done;
        s  = cyc;
        send_frame(8'hEC, 1'b1, 1'b1, 0, 1'b0);
        tick(10);
        chk("ec_data", {24'd0, bus.data}, 32'hEC);
        chk("ec_done_count", n_done - nd, 1);
        chk("ec_latency", last_done - s, 155);

        send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b0);
        tick(5);
        nd = n_done;
        nf = n_ferr;
        s  = cyc;
        send_frame(8'h3C, 1'b0, 1'b1, 40, 1'b0);
        tick(5);
        chk("ferr_data_held", {24'd0, bus.data}, 32'hA5);
        chk("ferr_count", n_ferr - nf, 1);
        chk("ferr_no_done", n_done - nd, 0);
        chk("ferr_latency", last_ferr - s, 155);
        send_frame(8'h0F, 1'b1, 1'b1, 0, 1'b0);
        tick(5);
        chk("after_ferr_data", {24'd0, bus.data}, 32'h0F);

        nd = n_done;
        glitch(5, 1'b1);
        tick(5);
        send_frame(8'h55, 1'b1, 1'b0, 0, 1'b0);
        tick(5);
        chk("glitch_dis_no_done", n_done - nd, 0);
        chk("glitch_dis_data", {24'd0, bus.data}, 32'h0F);

        nd = n_done;
        nf = n_ferr;
        s  = cyc;
        sched_busy(s + 3, s + 88);
        bus.rx_en = 1'b1;
        bus.rx    = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            bus.rx = 1'b1;
            tick(CPB);
        end
        tick(HALF);
        rst = 1'b0;
        tick(2);
        chk("midrst_busy", {31'd0, bus.busy}, 32'h0);
        chk("midrst_data", {24'd0, bus.data}, 32'h0);
        bus.rx = 1'b1;
        rst    = 1'b1;
        tick(5);
        send_frame(8'h81, 1'b1, 1'b1, 0, 1'b0);
        tick(5);
        chk("midrst_next_data", {24'd0, bus.data}, 32'h81);
        chk("midrst_done_count", n_done - nd, 1);
        chk("midrst_no_ferr", n_ferr - nf, 0);

        for (int k = 0; k < 30; k++) begin
            kind = $urandom_range(0, 9);
            b    = 8'($urandom_range(0, 255));
            if (kind <= 5)
                send_frame(b, 1'b1, 1'b1, 0, 1'($urandom_range(0, 1)));
            else if (kind == 6)
                send_frame(b, 1'b0, 1'b1, $urandom_range(0, 30), 1'b0);
            else if (kind == 7)
                send_frame(b, 1'b1, 1'b0, 0, 1'b0);
            else
                glitch($urandom_range(1, HALF - 1), kind == 8);
            if ($urandom_range(0, 3) != 0) tick($urandom_range(1, 20));
        end
        tick(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
